// File: rtl/alu_exec.sv
// Execute stage: single-cycle ADD/SUB/logic/PASS, iterative one-bit-per-cycle shifts.
// Result and N/Z/C flags are registered and change only when an op completes.
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   aluOp,
  input  logic [WIDTH-1:0] ALUop1,
  input  logic [WIDTH-1:0] ALUop2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_AND = OPW'(2);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR = OPW'(6);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} stateType;

  stateType         state, stateNext;
  logic [WIDTH-1:0] shiftReg, shiftRegNext;
  logic [SHW-1:0]   shiftCount, shiftCountNext;
  logic             shiftLeft, shiftLeftNext;
  logic [WIDTH-1:0] resultNext;
  logic             zeroNext, negativeNext, carryNext, busyNext, doneNext;

  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shiftAmt;
  logic [WIDTH-1:0] shiftStep;
  logic             shiftOut;
  logic [WIDTH-1:0] opResult;
  logic             opCarry, update;

  assign sum       = {1'b0, ALUop1} + {1'b0, ALUop2};
  assign diff      = {1'b0, ALUop1} - {1'b0, ALUop2};
  assign shiftAmt  = ALUop2[SHW-1:0];
  assign shiftStep = shiftLeft ? (shiftReg << 1) : (shiftReg >> 1);
  assign shiftOut  = shiftLeft ? shiftReg[WIDTH-1] : shiftReg[0];

  // Next-state logic; "update" marks a completion edge that commits result, flags and done.
  always_comb begin
    stateNext      = state;
    shiftRegNext   = shiftReg;
    shiftCountNext = shiftCount;
    shiftLeftNext  = shiftLeft;
    busyNext       = busy;
    opResult       = '0;
    opCarry        = 1'b0;
    update         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          update = 1'b1;
          case (aluOp)
            OP_ADD: begin
              opResult = sum[WIDTH-1:0];
              opCarry  = sum[WIDTH];
            end
            OP_SUB: begin
              opResult = diff[WIDTH-1:0];
              opCarry  = ~diff[WIDTH];
            end
            OP_AND: opResult = ALUop1 & ALUop2;
            OP_OR:  opResult = ALUop1 | ALUop2;
            OP_XOR: opResult = ALUop1 ^ ALUop2;
            OP_SHL, OP_SHR: begin
              if (shiftAmt == '0) begin
                opResult = ALUop1;
              end else begin
                update         = 1'b0;
                stateNext      = SHIFT;
                busyNext       = 1'b1;
                shiftRegNext   = ALUop1;
                shiftCountNext = shiftAmt;
                shiftLeftNext  = (aluOp == OP_SHL);
              end
            end
            default: opResult = ALUop2;
          endcase
        end
      end
      SHIFT: begin
        shiftRegNext   = shiftStep;
        shiftCountNext = shiftCount - SHW'(1);
        if (shiftCount == SHW'(1)) begin
          update    = 1'b1;
          opResult  = shiftStep;
          opCarry   = shiftOut;
          stateNext = IDLE;
          busyNext  = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase

    resultNext   = update ? opResult : result;
    carryNext    = update ? opCarry : carry;
    zeroNext     = update ? (opResult == '0) : zero;
    negativeNext = update ? opResult[WIDTH-1] : negative;
    doneNext     = update;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      shiftCount <= '0;
      shiftLeft  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftRegNext;
      shiftCount <= shiftCountNext;
      shiftLeft  <= shiftLeftNext;
      result     <= resultNext;
      zero       <= zeroNext;
      negative   <= negativeNext;
      carry      <= carryNext;
      busy       <= busyNext;
      done       <= doneNext;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: expected results queued on issue, popped and compared on done.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] aluOp = 3'd0;
  logic [7:0] ALUop1 = 8'h00;
  logic [7:0] ALUop2 = 8'h00;
  logic [7:0] result;
  logic       zero, negative, carry, busy, done;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
  } expType;

  expType sb[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] prevResult;

  alu_exec #(.WIDTH(8), .OPW(3), .SHW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .aluOp(aluOp),
    .ALUop1(ALUop1), .ALUop2(ALUop2), .result(result), .zero(zero),
    .negative(negative), .carry(carry), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic expType model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    expType e;
    logic [8:0] w;
    int n;
    e.c = 1'b0;
    e.res = 8'h00;
    n = int'(b[2:0]);
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; e.res = w[7:0]; e.c = w[8]; end
      3'd1: begin e.res = a - b; e.c = (a >= b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        e.res = a;
        for (int i = 0; i < n; i++) begin e.c = e.res[7]; e.res = {e.res[6:0], 1'b0}; end
      end
      3'd6: begin
        e.res = a;
        for (int i = 0; i < n; i++) begin e.c = e.res[0]; e.res = {1'b0, e.res[7:1]}; end
      end
      default: e.res = b;
    endcase
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    aluOp  = op;
    ALUop1 = a;
    ALUop2 = b;
    start  = 1'b1;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLat);
    int lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    expType e;
    if (done === 1'b1) begin
      checkOutput("sb_pending", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("sb_result", result, e.res);
        checkOutput("sb_zero", zero, e.z);
        checkOutput("sb_negative", negative, e.n);
        checkOutput("sb_carry", carry, e.c);
      end
    end
  end

  initial begin
    $display("[TB] alu_exec directed test");
    repeat (2) @(negedge clk);
    checkOutput("rst_result", result, 8'h00);
    checkOutput("rst_flags", {zero, negative, carry}, 3'b000);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3'd0, 8'hF0, 8'h20);
    checkOutput("add_done", done, 1);
    checkOutput("add_busy", busy, 0);
    checkOutput("add_result", result, 8'h10);
    checkOutput("add_flags", {zero, negative, carry}, 3'b001);
    @(negedge clk);
    checkOutput("add_done_pulse", done, 0);

    applyStimulus(3'd7, 8'h55, 8'h00);
    checkOutput("pass_result", {result, zero, carry}, {8'h00, 1'b1, 1'b0});

    applyStimulus(3'd1, 8'h05, 8'h05);
    waitDone("sub0", 0);
    checkOutput("sub0_result", {result, zero, carry}, {8'h00, 1'b1, 1'b1});
    applyStimulus(3'd1, 8'h03, 8'h05);
    checkOutput("sub1_result", {result, negative, carry}, {8'hFE, 1'b1, 1'b0});

    applyStimulus(3'd3, 8'h80, 8'h01);
    checkOutput("or_result", {result, negative}, {8'h81, 1'b1});

    prevResult = result;
    applyStimulus(3'd5, 8'hA1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      checkOutput("shl_busy", busy, 1);
      checkOutput("shl_hold", {result, done}, {prevResult, 1'b0});
      @(negedge clk);
    end
    checkOutput("shl_done", {done, busy}, 2'b10);
    checkOutput("shl_result", {result, carry}, {8'h08, 1'b1});
    @(negedge clk);
    checkOutput("shl_done_pulse", done, 0);

    applyStimulus(3'd5, 8'hA1, 8'h03);
    ALUop1 = 8'hFF;
    ALUop2 = 8'hFF;
    aluOp  = 3'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("shl2", 2);
    checkOutput("shl2_result", {result, carry}, {8'h08, 1'b1});
    @(negedge clk);
    checkOutput("shl2_no_second_done", done, 0);

    applyStimulus(3'd6, 8'h01, 8'hF9);
    waitDone("shr1", 1);
    checkOutput("shr1_result", {result, zero, carry}, {8'h00, 1'b1, 1'b1});
    applyStimulus(3'd6, 8'h01, 8'h08);
    waitDone("shr0", 0);
    checkOutput("shr0_result", {result, zero, carry}, {8'h01, 1'b0, 1'b0});

    applyStimulus(3'd5, 8'hA1, 8'h03);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_result", result, 8'h00);
    checkOutput("midrst_status", {zero, negative, carry, busy, done}, 5'b00000);
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(3'd0, 8'h01, 8'h01);
    checkOutput("postrst_add", {done, result}, {1'b1, 8'h02});

    applyStimulus(3'd4, 8'hFF, 8'h0F);
    checkOutput("b2b_xor", {done, result}, {1'b1, 8'hF0});
    applyStimulus(3'd2, 8'h3C, 8'hF0);
    checkOutput("b2b_and", {done, result}, {1'b1, 8'h30});
    @(negedge clk);
    checkOutput("b2b_done_end", done, 0);

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
